// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store write-back stage: func3 access widths,
// write-back selects, CSR operations, exception causes and FSM states.
package lsu_pkg;

    // func3 access size/sign codes
    localparam logic [2:0] WidthB  = 3'b000;
    localparam logic [2:0] WidthH  = 3'b001;
    localparam logic [2:0] WidthW  = 3'b010;
    localparam logic [2:0] WidthD  = 3'b011;
    localparam logic [2:0] WidthBu = 3'b100;
    localparam logic [2:0] WidthHu = 3'b101;
    localparam logic [2:0] WidthWu = 3'b110;

    // Write-back source selects
    localparam logic [1:0] WbAlu  = 2'b00;
    localparam logic [1:0] WbPc4  = 2'b01;
    localparam logic [1:0] WbCsr  = 2'b10;
    localparam logic [1:0] WbLoad = 2'b11;

    // CSR operations
    localparam logic [1:0] CsrNone = 2'b00;
    localparam logic [1:0] CsrRw   = 2'b01;
    localparam logic [1:0] CsrRs   = 2'b10;
    localparam logic [1:0] CsrRc   = 2'b11;

    // Exception causes
    localparam logic [3:0] CauseLdMisal = 4'd4;
    localparam logic [3:0] CauseLdFault = 4'd5;
    localparam logic [3:0] CauseStMisal = 4'd6;
    localparam logic [3:0] CauseStFault = 4'd7;

    typedef enum logic [1:0] {StIdle, StReq, StResp, StHold} lsu_state_e;

    // Doubleword and unsigned-word accesses only exist on a 64-bit datapath.
    function automatic logic width_legal(input logic [2:0] width, input logic is_rv64);
        case (width)
            WidthB, WidthH, WidthW, WidthBu, WidthHu: return 1'b1;
            WidthD, WidthWu:                          return is_rv64;
            default:                                  return 1'b0;
        endcase
    endfunction

    // Low address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] size_mask(input logic [2:0] width);
        return 3'((4'd1 << width[1:0]) - 4'd1);
    endfunction

endpackage

// File: rtl/lsu_wb_if.sv
// Memory request/response bus between the load/store stage and memory.
interface lsu_wb_if #(
    parameter int unsigned XLEN = 32
);
    localparam int unsigned STRB_W = XLEN / 8;

    logic              req_valid;
    logic              req_ready;
    logic              req_wen;
    logic [XLEN-1:0]   req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic [STRB_W-1:0] req_wmask;
    logic              resp_valid;
    logic [XLEN-1:0]   resp_data;
    logic              resp_err;

    modport master (
        output req_valid, req_wen, req_addr, req_wdata, req_wmask,
        input  req_ready, resp_valid, resp_data, resp_err
    );

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, req_wmask,
        output req_ready, resp_valid, resp_data, resp_err
    );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering: store data/strobe placement and load extraction with
// sign or zero extension. Purely combinational.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [2:0]                 width,
    input  logic [$clog2(XLEN/8)-1:0] offset,
    input  logic [XLEN-1:0]            st_data,
    input  logic [XLEN-1:0]            ld_raw,
    output logic [XLEN/8-1:0]          wmask,
    output logic [XLEN-1:0]            wdata,
    output logic [XLEN-1:0]            ld_data
);
    localparam int unsigned STRB_W = XLEN / 8;

    logic [STRB_W-1:0] size_ones;
    logic [XLEN-1:0]   shifted;

    // Place store bytes into their lanes and pull load bytes down to bit 0
    always_comb begin
        case (width[1:0])
            2'b00:   size_ones = STRB_W'(1);
            2'b01:   size_ones = STRB_W'(3);
            2'b10:   size_ones = STRB_W'(15);
            default: size_ones = '1;
        endcase
        wmask   = size_ones << offset;
        wdata   = st_data << {offset, 3'b000};
        shifted = ld_raw >> {offset, 3'b000};
        case (width)
            WidthB:  ld_data = XLEN'($signed(shifted[7:0]));
            WidthH:  ld_data = XLEN'($signed(shifted[15:0]));
            WidthW:  ld_data = XLEN'($signed(shifted[31:0]));
            WidthBu: ld_data = XLEN'(shifted[7:0]);
            WidthHu: ld_data = XLEN'(shifted[15:0]);
            WidthWu: ld_data = XLEN'(shifted[31:0]);
            default: ld_data = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_wb.sv
// Load/store and write-back stage: accepts one op from execute, performs an
// optional memory access over a valid/ready bus, and presents the register
// and CSR write-back (or an exception) to the downstream consumer.
module lsu_wb
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned STRB_W  = XLEN / 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_mem_ren,
    input  logic            in_mem_wen,
    input  logic [2:0]      in_width,
    input  logic [1:0]      in_wb_sel,
    input  logic [1:0]      in_csr_op,
    input  logic [4:0]      in_rd,
    input  logic            in_rd_wen,
    input  logic [XLEN-1:0] in_alu_res,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_csr_out,
    lsu_wb_if.master        mem,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_rd_wen,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_wdata,
    output logic            out_csr_wen,
    output logic [XLEN-1:0] out_csr_in,
    output logic            out_exc,
    output logic [3:0]      out_exc_cause
);
    localparam int unsigned OffW    = $clog2(STRB_W);
    localparam int unsigned CntW    = $clog2(TIMEOUT + 1);
    localparam logic        IsRv64  = (XLEN == 64);

    lsu_state_e st_q, st_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            exc_q, exc_d;
    logic [3:0]      cause_q, cause_d;
    logic [XLEN-1:0] ld_raw_q;
    logic            cap_ld;

    logic            is_store_q, rd_wen_q;
    logic [2:0]      width_q;
    logic [1:0]      wb_sel_q, csr_op_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] alu_q, rs1_q, rs2_q, pc_q, csr_out_q;

    logic            accept, mem_op, bad_access, tmo_hit, busy_q, busy_d;
    logic [3:0]      fault_cause;
    logic [STRB_W-1:0] al_wmask;
    logic [XLEN-1:0] al_wdata, al_ld_data;

    assign accept      = in_valid && (st_q == StIdle);
    assign mem_op      = in_mem_ren || in_mem_wen;
    assign bad_access  = !width_legal(in_width, IsRv64) ||
                         (|(in_alu_res[2:0] & size_mask(in_width)));
    assign tmo_hit     = (cnt_q == CntW'(TIMEOUT - 1));
    assign fault_cause = is_store_q ? CauseStFault : CauseLdFault;
    assign busy_q      = (st_q == StReq) || (st_q == StResp);
    assign busy_d      = (st_d == StReq) || (st_d == StResp);

    // Next state, exception capture and timeout counter
    always_comb begin
        st_d    = st_q;
        exc_d   = exc_q;
        cause_d = cause_q;
        cap_ld  = 1'b0;
        case (st_q)
            StIdle: begin
                if (in_valid) begin
                    exc_d   = 1'b0;
                    cause_d = '0;
                    if (!mem_op) begin
                        st_d = StHold;
                    end else if (bad_access) begin
                        st_d    = StHold;
                        exc_d   = 1'b1;
                        cause_d = in_mem_wen ? CauseStMisal : CauseLdMisal;
                    end else begin
                        st_d = StReq;
                    end
                end
            end
            StReq: begin
                if (tmo_hit) begin
                    st_d    = StHold;
                    exc_d   = 1'b1;
                    cause_d = fault_cause;
                end else if (mem.req_ready) begin
                    st_d = StResp;
                end
            end
            StResp: begin
                // A response arriving on the terminal count takes precedence
                if (mem.resp_valid) begin
                    st_d    = StHold;
                    cap_ld  = 1'b1;
                    exc_d   = mem.resp_err;
                    cause_d = mem.resp_err ? fault_cause : '0;
                end else if (tmo_hit) begin
                    st_d    = StHold;
                    exc_d   = 1'b1;
                    cause_d = fault_cause;
                end
            end
            StHold: begin
                if (out_ready) st_d = StIdle;
            end
            default: st_d = StIdle;
        endcase
        cnt_d = (busy_q && busy_d) ? cnt_q + CntW'(1) : '0;
    end

    // FSM, counter, exception and load-data registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q     <= StIdle;
            cnt_q    <= '0;
            exc_q    <= 1'b0;
            cause_q  <= '0;
            ld_raw_q <= '0;
        end else begin
            st_q    <= st_d;
            cnt_q   <= cnt_d;
            exc_q   <= exc_d;
            cause_q <= cause_d;
            if (cap_ld) ld_raw_q <= mem.resp_data;
        end
    end

    // Operand latch on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_store_q <= 1'b0;
            rd_wen_q   <= 1'b0;
            width_q    <= '0;
            wb_sel_q   <= '0;
            csr_op_q   <= '0;
            rd_q       <= '0;
            alu_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            pc_q       <= '0;
            csr_out_q  <= '0;
        end else if (accept) begin
            is_store_q <= in_mem_wen;
            rd_wen_q   <= in_rd_wen;
            width_q    <= in_width;
            wb_sel_q   <= in_wb_sel;
            csr_op_q   <= in_csr_op;
            rd_q       <= in_rd;
            alu_q      <= in_alu_res;
            rs1_q      <= in_rs1;
            rs2_q      <= in_rs2;
            pc_q       <= in_pc;
            csr_out_q  <= in_csr_out;
        end
    end

    lsu_align #(
        .XLEN (XLEN)
    ) u_align (
        .width   (width_q),
        .offset  (alu_q[OffW-1:0]),
        .st_data (rs2_q),
        .ld_raw  (ld_raw_q),
        .wmask   (al_wmask),
        .wdata   (al_wdata),
        .ld_data (al_ld_data)
    );

    // Bus request fields and write-back outputs, all derived from latched state
    always_comb begin
        in_ready       = (st_q == StIdle);
        mem.req_valid  = (st_q == StReq);
        mem.req_wen    = is_store_q;
        mem.req_addr   = alu_q & ~XLEN'(STRB_W - 1);
        mem.req_wdata  = is_store_q ? al_wdata : '0;
        mem.req_wmask  = is_store_q ? al_wmask : '0;
        out_valid      = (st_q == StHold);
        out_rd         = rd_q;
        out_exc        = out_valid && exc_q;
        out_exc_cause  = out_exc ? cause_q : '0;
        out_rd_wen     = out_valid && rd_wen_q && !exc_q;
        out_csr_wen    = out_valid && (csr_op_q != CsrNone) && !exc_q;
        case (wb_sel_q)
            WbAlu:   out_wdata = alu_q;
            WbPc4:   out_wdata = pc_q + XLEN'(4);
            WbCsr:   out_wdata = csr_out_q;
            default: out_wdata = al_ld_data;
        endcase
        case (csr_op_q)
            CsrRw:   out_csr_in = rs1_q;
            CsrRs:   out_csr_in = csr_out_q | rs1_q;
            CsrRc:   out_csr_in = csr_out_q & ~rs1_q;
            default: out_csr_in = '0;
        endcase
    end

endmodule

// File: tb/tb_lsu_wb.sv
// Directed bench for lsu_wb (XLEN=32, TIMEOUT=8): expected write-back results
// are queued when an op is issued and compared when out_valid appears.
module tb_lsu_wb;

    localparam int unsigned XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid, in_ready, in_mem_ren, in_mem_wen, in_rd_wen;
    logic [2:0]      in_width;
    logic [1:0]      in_wb_sel, in_csr_op;
    logic [4:0]      in_rd;
    logic [XLEN-1:0] in_alu_res, in_rs1, in_rs2, in_pc, in_csr_out;
    logic            out_valid, out_ready, out_rd_wen, out_csr_wen, out_exc;
    logic [4:0]      out_rd;
    logic [XLEN-1:0] out_wdata, out_csr_in;
    logic [3:0]      out_exc_cause;

    lsu_wb_if #(.XLEN(XLEN)) mem_bus ();

    lsu_wb #(
        .XLEN    (XLEN),
        .TIMEOUT (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_mem_ren    (in_mem_ren),
        .in_mem_wen    (in_mem_wen),
        .in_width      (in_width),
        .in_wb_sel     (in_wb_sel),
        .in_csr_op     (in_csr_op),
        .in_rd         (in_rd),
        .in_rd_wen     (in_rd_wen),
        .in_alu_res    (in_alu_res),
        .in_rs1        (in_rs1),
        .in_rs2        (in_rs2),
        .in_pc         (in_pc),
        .in_csr_out    (in_csr_out),
        .mem           (mem_bus),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_rd_wen    (out_rd_wen),
        .out_rd        (out_rd),
        .out_wdata     (out_wdata),
        .out_csr_wen   (out_csr_wen),
        .out_csr_in    (out_csr_in),
        .out_exc       (out_exc),
        .out_exc_cause (out_exc_cause)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic        rd_wen;
        logic [31:0] wdata;
        logic        csr_wen;
        logic [31:0] csr_in;
        logic        exc;
        logic [3:0]  cause;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [4:0] rd, input logic rd_wen, input logic [31:0] wdata,
                        input logic csr_wen, input logic [31:0] csr_in, input logic exc,
                        input logic [3:0] cause);
        exp_t e;
        e.rd = rd; e.rd_wen = rd_wen; e.wdata = wdata; e.csr_wen = csr_wen;
        e.csr_in = csr_in; e.exc = exc; e.cause = cause;
        sb.push_back(e);
    endtask

    // Present one op and let it be accepted on the next edge
    task automatic issue(input logic ren, input logic wen, input logic [2:0] width,
                         input logic [1:0] wb_sel, input logic [1:0] csr_op,
                         input logic [4:0] rd, input logic rd_wen, input logic [31:0] alu,
                         input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] pc, input logic [31:0] csr_out);
        in_mem_ren = ren; in_mem_wen = wen; in_width = width; in_wb_sel = wb_sel;
        in_csr_op = csr_op; in_rd = rd; in_rd_wen = rd_wen; in_alu_res = alu;
        in_rs1 = rs1; in_rs2 = rs2; in_pc = pc; in_csr_out = csr_out;
        in_valid = 1'b1;
        check("accept_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
    endtask

    // Memory side: hold off ready for 'delay' cycles, then answer at once
    task automatic serve(input int delay, input logic [31:0] data, input logic err);
        for (int i = 0; i < delay; i++) begin
            check("req_wait_valid", mem_bus.req_valid, 1);
            tick();
        end
        check("req_valid", mem_bus.req_valid, 1);
        mem_bus.req_ready = 1'b1;
        tick();
        mem_bus.req_ready = 1'b0;
        check("resp_wait_req_low", mem_bus.req_valid, 0);
        mem_bus.resp_valid = 1'b1;
        mem_bus.resp_data  = data;
        mem_bus.resp_err   = err;
        tick();
        mem_bus.resp_valid = 1'b0;
        mem_bus.resp_err   = 1'b0;
    endtask

    // Wait (bounded) for a result, compare against the scoreboard head, retire it
    task automatic expect_out(input string tag);
        exp_t e;
        int   n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_sb_nonempty"}, sb.size() != 0, 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_rd"}, out_rd, e.rd);
            check({tag, "_rd_wen"}, out_rd_wen, e.rd_wen);
            check({tag, "_wdata"}, out_wdata, e.wdata);
            check({tag, "_csr_wen"}, out_csr_wen, e.csr_wen);
            check({tag, "_csr_in"}, out_csr_in, e.csr_in);
            check({tag, "_exc"}, out_exc, e.exc);
            check({tag, "_cause"}, out_exc_cause, e.cause);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_back_idle"}, in_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_mem_ren = 1'b0; in_mem_wen = 1'b0; in_width = '0; in_wb_sel = '0;
        in_csr_op = '0; in_rd = '0; in_rd_wen = 1'b0; in_alu_res = '0; in_rs1 = '0;
        in_rs2 = '0; in_pc = '0; in_csr_out = '0;
        mem_bus.req_ready = 1'b0; mem_bus.resp_valid = 1'b0;
        mem_bus.resp_data = '0; mem_bus.resp_err = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_req_valid", mem_bus.req_valid, 0);
        check("rst_req_addr", mem_bus.req_addr, 0);
        check("rst_wdata", out_wdata, 0);
        check("rst_exc", out_exc, 0);
        check("rst_rd_wen", out_rd_wen, 0);

        // lb from the top byte lane, sign-extended
        push(5'd5, 1'b1, 32'hFFFF_FF80, 1'b0, 32'h0, 1'b0, 4'd0);
        issue(1, 0, 3'b000, 2'b11, 2'b00, 5'd5, 1, 32'h8000_0003, 0, 0, 0, 0);
        check("lb_addr", mem_bus.req_addr, 32'h8000_0000);
        check("lb_wmask", mem_bus.req_wmask, 4'b0000);
        check("lb_wen", mem_bus.req_wen, 0);
        serve(0, 32'h80AB_CDEF, 1'b0);
        expect_out("lb");

        // sh to the upper half-word, request held while ready is low
        push(5'd0, 1'b0, 32'h0000_0102, 1'b0, 32'h0, 1'b0, 4'd0);
        issue(0, 1, 3'b001, 2'b00, 2'b00, 5'd0, 0, 32'h0000_0102, 0, 32'h0000_1234, 0, 0);
        for (int i = 0; i < 3; i++) begin
            check("sh_valid", mem_bus.req_valid, 1);
            check("sh_wdata", mem_bus.req_wdata, 32'h1234_0000);
            check("sh_wmask", mem_bus.req_wmask, 4'b1100);
            check("sh_addr", mem_bus.req_addr, 32'h0000_0100);
            check("sh_wen", mem_bus.req_wen, 1);
            tick();
        end
        serve(0, 32'h0, 1'b0);
        expect_out("sh");

        // lhu from the upper half, zero-extended
        push(5'd9, 1'b1, 32'h0000_8765, 1'b0, 32'h0, 1'b0, 4'd0);
        issue(1, 0, 3'b101, 2'b11, 2'b00, 5'd9, 1, 32'h0000_0202, 0, 0, 0, 0);
        serve(1, 32'h8765_4321, 1'b0);
        expect_out("lhu");

        // Misaligned lw: no bus request, exception one cycle after accept
        push(5'd3, 1'b0, 32'h0000_0101, 1'b0, 32'h0, 1'b1, 4'd4);
        issue(1, 0, 3'b010, 2'b00, 2'b00, 5'd3, 1, 32'h0000_0101, 0, 0, 0, 0);
        check("misal_req_valid", mem_bus.req_valid, 0);
        check("misal_latency", out_valid, 1);
        expect_out("misal");

        // ld is illegal on a 32-bit datapath
        push(5'd4, 1'b0, 32'h0000_0008, 1'b0, 32'h0, 1'b1, 4'd4);
        issue(1, 0, 3'b011, 2'b00, 2'b00, 5'd4, 1, 32'h0000_0008, 0, 0, 0, 0);
        check("ld32_req_valid", mem_bus.req_valid, 0);
        expect_out("ld32");

        // sw answered with a bus error
        push(5'd6, 1'b0, 32'h0000_0400, 1'b0, 32'h0, 1'b1, 4'd7);
        issue(0, 1, 3'b010, 2'b00, 2'b00, 5'd6, 1, 32'h0000_0400, 0, 32'hDEAD_BEEF, 0, 0);
        check("sw_wmask", mem_bus.req_wmask, 4'b1111);
        serve(0, 32'h0, 1'b1);
        expect_out("sw_err");

        // lw with no response: fault exactly TIMEOUT cycles after entering REQ
        push(5'd8, 1'b0, 32'h0000_0200, 1'b0, 32'h0, 1'b1, 4'd5);
        issue(1, 0, 3'b010, 2'b00, 2'b00, 5'd8, 1, 32'h0000_0200, 0, 0, 0, 0);
        mem_bus.req_ready = 1'b1;
        tick();
        mem_bus.req_ready = 1'b0;
        n = 1;
        while (out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("tmo_latency", n, 8);
        mem_bus.resp_valid = 1'b1;
        mem_bus.resp_data  = 32'h1111_1111;
        tick();
        check("tmo_stray_valid", out_valid, 1);
        check("tmo_stray_cause", out_exc_cause, 4'd5);
        expect_out("tmo");
        tick();
        check("tmo_stray_idle", in_ready, 1);
        check("tmo_stray_no_out", out_valid, 0);
        mem_bus.resp_valid = 1'b0;

        // csrrc with a stalled consumer: outputs frozen, no new accept
        push(5'd7, 1'b1, 32'h0000_00FF, 1'b1, 32'h0000_00F0, 1'b0, 4'd0);
        issue(0, 0, 3'b000, 2'b10, 2'b11, 5'd7, 1, 0, 32'h0F, 0, 0, 32'hFF);
        for (int i = 0; i < 4; i++) begin
            check("csrrc_hold_valid", out_valid, 1);
            check("csrrc_hold_ready", in_ready, 0);
            check("csrrc_hold_wdata", out_wdata, 32'h0000_00FF);
            check("csrrc_hold_csr_in", out_csr_in, 32'h0000_00F0);
            in_rs1 = $urandom;
            in_csr_out = $urandom;
            tick();
        end
        expect_out("csrrc");

        // csrrs with pc+4 wrapping to zero
        push(5'd1, 1'b1, 32'h0, 1'b1, 32'h0000_00FF, 1'b0, 4'd0);
        issue(0, 0, 3'b000, 2'b01, 2'b10, 5'd1, 1, 0, 32'h0F, 0, 32'hFFFF_FFFC, 32'hF0);
        expect_out("pc4");

        // Reset pulsed while waiting for a response
        issue(1, 0, 3'b010, 2'b11, 2'b00, 5'd2, 1, 32'h0000_0300, 0, 0, 0, 0);
        mem_bus.req_ready = 1'b1;
        tick();
        mem_bus.req_ready = 1'b0;
        check("rstmid_busy", in_ready, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rstmid_in_ready", in_ready, 1);
        check("rstmid_out_valid", out_valid, 0);
        check("rstmid_req_valid", mem_bus.req_valid, 0);
        mem_bus.resp_valid = 1'b1;
        mem_bus.resp_data  = 32'h2222_2222;
        tick();
        mem_bus.resp_valid = 1'b0;
        check("rstmid_late_resp_idle", in_ready, 1);
        check("rstmid_late_resp_out", out_valid, 0);
        tick();
        check("rstmid_still_idle", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lsu_wb.md
Name: lsu_wb

Overview:
- Parametrised load/store and write-back stage; successor to the single-cycle combinational write-back unit.
- Replaces the asynchronous memory access with a valid/ready request/response bus.
- Adds misalignment and access-fault detection, a timeout, and CSR rw/rs/rc update generation.
- Sits between the execute stage (upstream handshake) and the register file / CSR file (downstream handshake).

Parameters:
- XLEN, 32, datapath and address width; legal values are 32 and 64.
- TIMEOUT, 255, maximum cycles spent in REQ+RESP before an access fault is raised.
- STRB_W, XLEN/8, byte-strobe width (derived; do not override).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream op valid
- in_ready  out  1  stage can accept
- in_mem_ren  in  1  load op
- in_mem_wen  in  1  store op
- in_width  in  3  func3 access size/sign
- in_wb_sel  in  2  00 alu, 01 pc+4, 10 csr_out, 11 load data
- in_csr_op  in  2  00 none, 01 rw, 10 rs, 11 rc
- in_rd  in  5  destination register
- in_rd_wen  in  1  register write request
- in_alu_res  in  XLEN  ALU result / effective address
- in_rs1  in  XLEN  rs1 value (CSR source)
- in_rs2  in  XLEN  store data
- in_pc  in  XLEN  instruction PC
- in_csr_out  in  XLEN  current CSR value
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory request accepted
- mem_req_wen  out  1  store request
- mem_req_addr  out  XLEN  address, aligned down to STRB_W bytes
- mem_req_wdata  out  XLEN  lane-shifted store data
- mem_req_wmask  out  STRB_W  byte strobes
- mem_resp_valid  in  1  response valid
- mem_resp_data  in  XLEN  raw read word
- mem_resp_err  in  1  bus error
- out_valid  out  1  write-back result valid
- out_ready  in  1  consumer accepts
- out_rd_wen  out  1  register write enable
- out_rd  out  5  destination register
- out_wdata  out  XLEN  register write data
- out_csr_wen  out  1  CSR write enable
- out_csr_in  out  XLEN  new CSR value
- out_exc  out  1  exception flag
- out_exc_cause  out  4  4/6 load/store misaligned; 5/7 load/store access fault

Behaviour:
- Reset (asynchronous, rst_n low): state IDLE; all outputs 0 except in_ready=1; timeout counter 0; latched operands cleared.
- Reset mid-transaction drops the outstanding request. Responses arriving after reset are ignored.
- States are IDLE, REQ, RESP and HOLD.
- in_ready=1 only in IDLE. The op and all operands are latched on in_valid&&in_ready.
- Transitions out of IDLE on accept:
  - no memory op: go to HOLD; out_valid asserts the next cycle (latency 1).
  - misaligned or illegal width: go to HOLD with out_exc=1 and no bus request.
  - otherwise: go to REQ.
- REQ: mem_req_valid=1 with all request fields stable until mem_req_ready; then go to RESP.
- RESP: mem_resp_valid is sampled only here. On response go to HOLD; load data is captured; mem_resp_err sets fault cause 5 or 7.
- mem_resp_valid outside RESP is ignored.
- Timeout: the counter increments each cycle in REQ/RESP. When it reaches TIMEOUT, go to HOLD with fault cause 5 or 7. The counter clears on leaving RESP/REQ.
- HOLD: out_* are held stable while out_valid=1 until out_ready; then go to IDLE. The next accept can happen no earlier than the following cycle.
- Width decode:
  - 000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu.
  - 011 ld/sd and 110 lwu are legal only when XLEN=64.
  - Other codes are illegal and give cause 4 (load) or 6 (store).
- Misaligned means the effective address is not a multiple of the access size.
- Store: wmask = size-ones << addr[log2(STRB_W)-1:0]; wdata = rs2 << (offset*8).
- Load: shift the response right by offset*8, then sign- or zero-extend per func3.
- out_wdata is selected by in_wb_sel. pc+4 is computed modulo 2^XLEN.
- CSR update: rw gives rs1; rs gives csr_out|rs1; rc gives csr_out&~rs1. out_csr_wen = (csr_op!=0).
- On exception, out_rd_wen=0 and out_csr_wen=0; out_rd is still reported.
- Simultaneous mem_resp_valid and timeout terminal count: the response wins.

Decomposition:
- Package lsu_pkg holds the func3 width codes, wb_sel codes, csr_op codes, exception cause codes and the state enum.
- One sub-module, lsu_align (combinational, parametrised XLEN), performs store lane/mask generation and load extraction/extension.
- The FSM, counter and handshakes stay in lsu_wb.

Test Plan:
- lb at addr 0x8000_0003, resp data 0x80AB_CDEF, XLEN=32 -> mem_req_addr 0x8000_0000, mem_req_wmask 0000, out_wdata 0xFFFF_FF80, out_rd_wen 1.
- sh at addr 0x102, rs2 0x0000_1234 -> mem_req_wdata 0x1234_0000, mem_req_wmask 1100; request held for 3 cycles with mem_req_ready low.
- lw at addr 0x101 -> no mem_req_valid; out_exc 1, cause 4, out_rd_wen 0; out_valid 1 cycle after accept.
- lw with memory never responding, TIMEOUT=8 -> out_exc 1, cause 5 exactly 8 cycles after entering REQ; a stray later response is ignored.
- csrrc with csr_out 0xFF, rs1 0x0F, wb_sel 10 -> out_csr_in 0xF0, out_wdata 0xFF; with out_ready low for 4 cycles, outputs stay stable and in_ready stays 0.
- rst_n pulsed low while in RESP -> next cycle state IDLE, in_ready 1, out_valid 0; a late mem_resp_valid is ignored.
